// File: rtl/hgcal_input_packer_pkg.sv
// Shared types and the threshold quantizer used by the HGCAL input packer
// and by any decoder-side checker that must reproduce the same 2-bit codes.
package hgcal_input_packer_pkg;

  localparam int Q_W = 2;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    COLLECT  = 2'd1,
    STALL    = 2'd2
  } state_e;

  function automatic logic [Q_W-1:0] quantize(input int unsigned x,
                                              input int unsigned t1,
                                              input int unsigned t2,
                                              input int unsigned t3);
    if (x >= t3)      return 2'd3;
    else if (x >= t2) return 2'd2;
    else if (x >= t1) return 2'd1;
    else              return 2'd0;
  endfunction

endpackage

// File: rtl/hgcal_sample_quantizer.sv
// Combinational 2-bit quantizer of one unsigned sample against T1 < T2 < T3.
module hgcal_sample_quantizer
  import hgcal_input_packer_pkg::*;
#(
  parameter int unsigned IN_W = 8,
  parameter int unsigned T1   = 16,
  parameter int unsigned T2   = 64,
  parameter int unsigned T3   = 192
) (
  input  logic [IN_W-1:0] x_i,
  output logic [Q_W-1:0]  q_o
);

  assign q_o = quantize(32'(x_i), T1, T2, T3);

endmodule

// File: rtl/hgcal_input_packer.sv
// Packs a sof-delimited sample stream into one 2*N_INPUTS-bit frame vector.
// Optional PACKER_ERRCNT_EN adds a saturating truncated-frame counter port.
module hgcal_input_packer
  import hgcal_input_packer_pkg::*;
#(
  parameter int unsigned N_INPUTS = 64,
  parameter int unsigned IN_W     = 8,
  parameter int unsigned T1       = 16,
  parameter int unsigned T2       = 64,
  parameter int unsigned T3       = 192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_sof,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2*N_INPUTS-1:0] out_vec,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef PACKER_ERRCNT_EN
  ,
  output logic [15:0]           err_cnt
`endif
);

  localparam int unsigned IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_INPUTS - 1);

  state_e                        state_q;
  logic [IDX_W-1:0]              idx_q;
  logic [N_INPUTS-1:0][Q_W-1:0]  acc_q, acc_d, out_q;
  logic                          out_valid_q, in_ready_q;
  logic [Q_W-1:0]                q;
  logic [IDX_W-1:0]              wr_idx;
  logic                          accept, out_free, frame_done;

  hgcal_sample_quantizer #(.IN_W(IN_W), .T1(T1), .T2(T2), .T3(T3)) u_quant (
    .x_i (in_data),
    .q_o (q)
  );

  assign accept   = in_valid & in_ready_q;
  assign out_free = ~out_valid_q | out_ready;
  assign wr_idx   = in_sof ? '0 : idx_q;

  // A sof restarts at slot 0; otherwise the sample lands at idx.
  always_comb begin
    acc_d         = acc_q;
    acc_d[wr_idx] = q;
  end

  always_comb begin
    frame_done = 1'b0;
    if (accept) begin
      if (state_q == WAIT_SOF) frame_done = in_sof && (N_INPUTS == 1);
      else if (state_q == COLLECT) frame_done = !in_sof && (idx_q == LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= WAIT_SOF;
      idx_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        WAIT_SOF, COLLECT: begin
          in_ready_q <= 1'b1;
          if (accept && (in_sof || state_q == COLLECT)) begin
            acc_q <= acc_d;
            if (in_sof) begin
              idx_q   <= IDX_W'(1);
              state_q <= COLLECT;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
            if (frame_done) begin
              idx_q <= '0;
              if (out_free) begin
                out_q       <= acc_d;
                out_valid_q <= 1'b1;
                state_q     <= WAIT_SOF;
              end else begin
                state_q    <= STALL;
                in_ready_q <= 1'b0;
              end
            end
          end
        end
        STALL: begin
          // out_valid is known high here, so out_ready alone means consume.
          if (out_ready) begin
            out_q       <= acc_q;
            out_valid_q <= 1'b1;
            state_q     <= WAIT_SOF;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= WAIT_SOF;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_vec   = out_q;
  assign out_valid = out_valid_q;

`ifdef PACKER_ERRCNT_EN
  logic [15:0] err_q;
  logic        trunc;

  assign trunc = accept && (state_q == COLLECT) && in_sof;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            err_q <= '0;
    else if (trunc && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
  end

  assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_hgcal_input_packer.sv
// Bench for hgcal_input_packer (N_INPUTS=4): table-driven frames checked via a
// scoreboard queue, plus back-pressure, truncation and reset sequences.
module tb_hgcal_input_packer;

  logic       clk, rst;
  logic [7:0] in_data;
  logic       in_sof, in_valid, in_ready;
  logic [7:0] out_vec;
  logic       out_valid, out_ready;
`ifdef PACKER_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  hgcal_input_packer #(.N_INPUTS(4), .IN_W(8), .T1(16), .T2(64), .T3(192)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_vec   (out_vec),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PACKER_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] d;
    logic [7:0]      exp;
  } vec_t;

  vec_t       tbl[4];
  logic [7:0] sb[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    int n = 0;
    in_data  = d;
    in_sof   = s;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready stuck at %b", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0][7:0] d);
    for (int i = 0; i < 4; i++) send(d[i], i == 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_vec", 32'(out_vec), 32'd0);
    sb.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PACKER_ERRCNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
  endtask

  // Scoreboard: every consumed frame must match the next expected vector.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame got %h expected none", out_vec);
      end else begin
        check("frame", 32'(out_vec), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    tbl[0].d = {8'd255, 8'd64, 8'd16, 8'd0};    tbl[0].exp = 8'hE4;
    tbl[1].d = {8'd192, 8'd191, 8'd63, 8'd15};  tbl[1].exp = 8'hE4;
    tbl[2].d = {8'd20, 8'd100, 8'd200, 8'd255}; tbl[2].exp = 8'h6F;
    tbl[3].d = {8'd1, 8'd17, 8'd65, 8'd193};    tbl[3].exp = 8'h1B;

    rst = 1'b0; in_data = '0; in_sof = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    do_reset();

    // Basic frames, out_valid must be a single-cycle pulse with out_ready=1
    for (int t = 0; t < 4; t++) begin
      sb.push_back(tbl[t].exp);
      send_frame(tbl[t].d);
      check("pulse_hi", 32'(out_valid), 32'd1);
      tick();
      check("pulse_lo", 32'(out_valid), 32'd0);
    end

    // Two frames back-to-back into a blocked output: A held, B parked in acc
    out_ready = 1'b0;
    sb.push_back(tbl[0].exp);
    sb.push_back(tbl[2].exp);
    send_frame(tbl[0].d);
    send_frame(tbl[2].d);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_out_vec", 32'(out_vec), 32'hE4);
    in_data = 8'd9; in_sof = 1'b1; in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0; in_sof = 1'b0;
    check("stall_hold_vec", 32'(out_vec), 32'hE4);
    check("stall_hold_rdy", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b_out_vec", 32'(out_vec), 32'h6F);
    check("b_out_valid", 32'(out_valid), 32'd1);
    check("b_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("b_hold_vec", 32'(out_vec), 32'h6F);
    out_ready = 1'b1;
    tick();
    check("b_consumed", 32'(out_valid), 32'd0);

    // Truncated frame is discarded and restarted at the new sof
    sb.push_back(8'h00);
    send(8'd200, 1'b1);
    send(8'd200, 1'b0);
    send(8'd5, 1'b1);
    for (int i = 0; i < 3; i++) send(8'd5, 1'b0);
    tick();
`ifdef PACKER_ERRCNT_EN
    check("trunc_err_cnt", 32'(err_cnt), 32'd1);
`endif

    // Samples without sof after reset are dropped
    do_reset();
    for (int i = 0; i < 3; i++) send(8'd255, 1'b0);
    tick();
    check("drop_out_valid", 32'(out_valid), 32'd0);
    check("drop_in_ready", 32'(in_ready), 32'd1);
`ifdef PACKER_ERRCNT_EN
    check("drop_err_cnt", 32'(err_cnt), 32'd0);
`endif

    // Reset mid-frame, then a clean frame
    send(8'd0, 1'b1);
    send(8'd0, 1'b0);
    do_reset();
    sb.push_back(8'hFF);
    for (int i = 0; i < 4; i++) send(8'd255, i == 0);
    check("clean_out_valid", 32'(out_valid), 32'd1);
    tick();
`ifdef PACKER_ERRCNT_EN
    check("clean_err_cnt", 32'(err_cnt), 32'd0);
`endif

    // Reset while in STALL discards both held frames
    out_ready = 1'b0;
    send_frame(tbl[3].d);
    send_frame(tbl[2].d);
    check("stall2_in_ready", 32'(in_ready), 32'd0);
    do_reset();
    out_ready = 1'b1;
    tick();
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
